// File: rtl/ring_scan_mux.sv
// Time-multiplexed channel selector driven by its own one-hot ring counter.
// Each unmasked channel is held for DWELL cycles and routed to out; masked channels are skipped.
module ring_scan_mux #(
  parameter int CHANNELS = 3,
  parameter int WIDTH    = 1,
  parameter int DWELL    = 1000
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic                      enable,
  input  logic [CHANNELS-1:0]       channel_mask,
  input  logic [CHANNELS*WIDTH-1:0] data_in,
  output logic [WIDTH-1:0]          out,
  output logic [CHANNELS-1:0]       ring_counter,
  output logic                      frame_done
);

  localparam int DW = (DWELL > 1) ? $clog2(DWELL) : 1;
  localparam int IW = $clog2(CHANNELS);

  logic [DW-1:0]       dwell_count;
  logic [DW-1:0]       dwell_next;
  logic [CHANNELS-1:0] ring_next;
  logic                frame_next;
  logic [IW-1:0]       cur_idx;
  logic [IW-1:0]       lowest_idx;
  logic [IW-1:0]       above_idx;
  logic                have_above;
  logic [IW-1:0]       target_idx;

  always_comb begin
    cur_idx = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      if (ring_counter[i]) cur_idx = IW'(i);
    end
  end

  // Descending scan leaves the lowest matching index in each result.
  always_comb begin
    lowest_idx = '0;
    above_idx  = '0;
    have_above = 1'b0;
    for (int i = CHANNELS - 1; i >= 0; i--) begin
      if (channel_mask[i]) begin
        lowest_idx = IW'(i);
        if (i > int'(cur_idx)) begin
          above_idx  = IW'(i);
          have_above = 1'b1;
        end
      end
    end
    target_idx = have_above ? above_idx : lowest_idx;
  end

  always_comb begin
    out = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      out = out | (data_in[i*WIDTH +: WIDTH] & {WIDTH{ring_counter[i]}});
    end
  end

  // A move without a higher enabled channel is a wrap, which ends the frame.
  always_comb begin
    ring_next  = ring_counter;
    dwell_next = dwell_count;
    frame_next = 1'b0;
    if (channel_mask == '0) begin
      ring_next  = '0;
      dwell_next = '0;
    end else if (ring_counter == '0) begin
      if (enable) begin
        ring_next  = CHANNELS'(1) << lowest_idx;
        dwell_next = '0;
      end
    end else if ((ring_counter & channel_mask) == '0) begin
      ring_next  = CHANNELS'(1) << target_idx;
      dwell_next = '0;
      frame_next = ~have_above;
    end else if (!enable) begin
      ring_next  = ring_counter;
      dwell_next = dwell_count;
    end else if (dwell_count == DW'(DWELL - 1)) begin
      ring_next  = CHANNELS'(1) << target_idx;
      dwell_next = '0;
      frame_next = ~have_above;
    end else begin
      dwell_next = dwell_count + DW'(1);
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      ring_counter <= '0;
      dwell_count  <= '0;
      frame_done   <= 1'b0;
    end else begin
      ring_counter <= ring_next;
      dwell_count  <= dwell_next;
      frame_done   <= frame_next;
    end
  end

endmodule

// File: tb/tb_ring_scan_mux.sv
// Scoreboard bench for ring_scan_mux: two instances (DWELL=4 and DWELL=1) share stimulus,
// an integer-index reference model queues expectations, and a monitor compares every cycle.
module tb_ring_scan_mux;

  localparam int CH = 3;
  localparam int W  = 4;

  logic          clock = 1'b0;
  logic          reset;
  logic          enable;
  logic [CH-1:0] channel_mask;
  logic [CH*W-1:0] data_in;
  logic [W-1:0]  out_a, out_b;
  logic [CH-1:0] ring_a, ring_b;
  logic          fd_a, fd_b;

  always #5 clock = ~clock;

  ring_scan_mux #(.CHANNELS(CH), .WIDTH(W), .DWELL(4)) dut (
    .clock(clock), .reset(reset), .enable(enable), .channel_mask(channel_mask),
    .data_in(data_in), .out(out_a), .ring_counter(ring_a), .frame_done(fd_a)
  );

  ring_scan_mux #(.CHANNELS(CH), .WIDTH(W), .DWELL(1)) dut_d1 (
    .clock(clock), .reset(reset), .enable(enable), .channel_mask(channel_mask),
    .data_in(data_in), .out(out_b), .ring_counter(ring_b), .frame_done(fd_b)
  );

  typedef struct {
    int cur;
    int dwell;
    bit fd;
  } model_t;

  typedef struct {
    logic [CH-1:0] ring_a;
    logic [W-1:0]  out_a;
    logic          fd_a;
    logic [CH-1:0] ring_b;
    logic [W-1:0]  out_b;
    logic          fd_b;
  } expect_t;

  expect_t exp_q[$];
  expect_t mon_e;
  model_t  m_a = '{-1, 0, 1'b0};
  model_t  m_b = '{-1, 0, 1'b0};
  int      checks = 0;
  int      errors = 0;

  function automatic int next_enabled(input logic [CH-1:0] mask, input int from);
    for (int k = 1; k <= CH; k++) begin
      int c;
      c = (from + k) % CH;
      if (mask[c]) return c;
    end
    return -1;
  endfunction

  // Channel index -1 stands for the idle (nothing selected) state.
  function automatic model_t model_step(input model_t s, input logic rst, input logic en,
                                        input logic [CH-1:0] mask, input int dwell_len);
    model_t n;
    n = s;
    n.fd = 1'b0;
    if (rst || mask == '0) begin
      n.cur = -1;
      n.dwell = 0;
    end else if (s.cur < 0) begin
      if (en) begin
        n.cur = next_enabled(mask, CH - 1);
        n.dwell = 0;
      end
    end else if (!mask[s.cur]) begin
      n.cur = next_enabled(mask, s.cur);
      n.dwell = 0;
      n.fd = (n.cur <= s.cur);
    end else if (!en) begin
      n = s;
      n.fd = 1'b0;
    end else if (s.dwell == dwell_len - 1) begin
      n.cur = next_enabled(mask, s.cur);
      n.dwell = 0;
      n.fd = (n.cur <= s.cur);
    end else begin
      n.dwell = s.dwell + 1;
    end
    return n;
  endfunction

  function automatic logic [CH-1:0] ring_of(input int cur);
    if (cur < 0) return '0;
    return CH'(1) << cur;
  endfunction

  function automatic logic [W-1:0] word_of(input int cur, input logic [CH*W-1:0] d);
    if (cur < 0) return '0;
    return d[cur*W +: W];
  endfunction

  task automatic check_output(input string name, input logic [31:0] actual, input logic [31:0] required);
    checks++;
    if (actual !== required) begin
      errors++;
      $display("[TB] FAIL %s at %0t: got %0h, expected %0h", name, $time, actual, required);
    end
  endtask

  task automatic apply_stimulus(input logic rst, input logic en,
                                input logic [CH-1:0] mask, input logic [CH*W-1:0] data);
    expect_t e;
    @(negedge clock);
    reset        = rst;
    enable       = en;
    channel_mask = mask;
    data_in      = data;
    m_a = model_step(m_a, rst, en, mask, 4);
    m_b = model_step(m_b, rst, en, mask, 1);
    e.ring_a = ring_of(m_a.cur);
    e.out_a  = word_of(m_a.cur, data);
    e.fd_a   = m_a.fd;
    e.ring_b = ring_of(m_b.cur);
    e.out_b  = word_of(m_b.cur, data);
    e.fd_b   = m_b.fd;
    exp_q.push_back(e);
  endtask

  // Every queued expectation belongs to the edge that follows its stimulus.
  always @(posedge clock) begin
    #1;
    if (exp_q.size() > 0) begin
      mon_e = exp_q.pop_front();
      check_output("ring_d4",  32'(ring_a), 32'(mon_e.ring_a));
      check_output("out_d4",   32'(out_a),  32'(mon_e.out_a));
      check_output("frame_d4", 32'(fd_a),   32'(mon_e.fd_a));
      check_output("ring_d1",  32'(ring_b), 32'(mon_e.ring_b));
      check_output("out_d1",   32'(out_b),  32'(mon_e.out_b));
      check_output("frame_d1", 32'(fd_b),   32'(mon_e.fd_b));
    end
  end

  initial begin
    logic [CH-1:0]   r_mask;
    logic [CH*W-1:0] r_data;
    reset        = 1'b1;
    enable       = 1'b1;
    channel_mask = 3'b111;
    data_in      = 12'hA53;

    repeat (2) apply_stimulus(1'b1, 1'b1, 3'b111, 12'hA53);
    repeat (14) apply_stimulus(1'b0, 1'b1, 3'b111, 12'hA53);

    apply_stimulus(1'b1, 1'b1, 3'b111, 12'hA53);
    repeat (6) apply_stimulus(1'b0, 1'b1, 3'b111, 12'hA53);
    repeat (14) apply_stimulus(1'b0, 1'b1, 3'b101, 12'hA53);
    repeat (2) apply_stimulus(1'b0, 1'b1, 3'b000, 12'hA53);

    apply_stimulus(1'b1, 1'b1, 3'b111, 12'hA53);
    repeat (7) apply_stimulus(1'b0, 1'b1, 3'b111, 12'hA53);
    repeat (10) apply_stimulus(1'b0, 1'b0, 3'b111, 12'($urandom));
    repeat (4) apply_stimulus(1'b0, 1'b1, 3'b111, 12'h6C9);

    repeat (12) apply_stimulus(1'b0, 1'b1, 3'b010, 12'h7B2);
    apply_stimulus(1'b0, 1'b1, 3'b110, 12'h7B2);

    r_mask = 3'b111;
    for (int n = 0; n < 400; n++) begin
      if ($urandom_range(0, 7) == 0) r_mask = CH'($urandom_range(0, 7));
      r_data = 12'($urandom);
      apply_stimulus(($urandom_range(0, 63) == 0), ($urandom_range(0, 5) != 0), r_mask, r_data);
    end

    repeat (2) @(negedge clock);
    check_output("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
